// File: rtl/cfg_rst_sequencer_pkg.sv
// Shared types, default parameters and helpers for the config-block reset
// sequencer.
//   state_t    : sequencer FSM states
//   *_DEF      : default parameter values
//   lowest_set : index of the lowest set bit of a MAX_RST-wide vector
package cfg_rst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    HOLD,
    RELEASE,
    GAP
  } state_t;

  localparam int unsigned N_RST_DEF       = 3;
  localparam int unsigned HOLD_CYCLES_DEF = 16;
  localparam int unsigned GAP_CYCLES_DEF  = 4;
  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned MAX_RST         = 8;
  localparam int unsigned IDX_W           = 3;

  // Returns 0 for an all-zero vector; callers qualify with an any-set flag.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_RST-1:0] vec);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_RST; i++) begin
      if (vec[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cfg_rst_sequencer_if.sv
// Request/response channel between the configuration master and the reset
// sequencer.
//   req_vld  : request valid (master -> slave)
//   req_mask : domains to reset, bit i = domain i (master -> slave)
//   req_rdy  : request accepted when req_vld & req_rdy at a rising edge
//   busy     : sequence in progress
//   done     : one-cycle pulse with the final release of a sequence
//   err      : one-cycle pulse after a zero-mask request is rejected
interface cfg_rst_sequencer_if
  import cfg_rst_pkg::*;
#(
  parameter int unsigned N_RST = N_RST_DEF
);

  logic             req_vld;
  logic [N_RST-1:0] req_mask;
  logic             req_rdy;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req_vld,
    output req_mask,
    input  req_rdy,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  req_vld,
    input  req_mask,
    output req_rdy,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/cfg_rst_sequencer_prio_enc.sv
// Combinational lowest-set-bit encoder.
//   vec : input vector
//   idx : index of the lowest set bit (0 when vec is zero)
//   any : vec has at least one bit set
module rst_prio_enc
  import cfg_rst_pkg::*;
#(
  parameter int unsigned N_RST = N_RST_DEF
) (
  input  logic [N_RST-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [MAX_RST-1:0] ext;

  always_comb begin
    ext            = '0;
    ext[N_RST-1:0] = vec;
    idx            = lowest_set(ext);
    any            = |vec;
  end

endmodule

// File: rtl/cfg_rst_sequencer.sv
// Reset sequencer for the core/EPE domains. Accepts a per-domain reset mask
// from the config master, drives the selected active-low resets, holds them
// for HOLD_CYCLES, then releases them one at a time in ascending index order
// with GAP_CYCLES between releases. Leaving block reset runs a full-mask
// release without a handshake.
//   clk     : clock
//   rst     : synchronous active-high block reset
//   bus     : request channel (slave side)
//   rst_out : domain resets, active-low
module cfg_rst_sequencer
  import cfg_rst_pkg::*;
#(
  parameter int unsigned N_RST       = N_RST_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  cfg_rst_sequencer_if.slave  bus,
  output logic [N_RST-1:0]    rst_out
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t             state, state_n;
  logic [N_RST-1:0]   pend, pend_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [N_RST-1:0]   rst_out_n;
  logic [N_RST-1:0]   sel;
  logic [N_RST-1:0]   remaining;
  logic [IDX_W-1:0]   idx;
  logic               any_pend;
  logic               done_n;
  logic               err_n;
  logic               err_pend;

  rst_prio_enc #(
    .N_RST (N_RST)
  ) u_enc (
    .vec (pend),
    .idx (idx),
    .any (any_pend)
  );

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_RST; i++) begin
      sel[i] = (idx == IDX_W'(i));
    end
    remaining = pend & ~sel;
  end

  always_comb begin
    state_n   = state;
    pend_n    = pend;
    cnt_n     = cnt;
    rst_out_n = rst_out;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_vld && bus.req_rdy) begin
          if (|bus.req_mask) begin
            pend_n  = bus.req_mask;
            state_n = ASSERT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ASSERT: begin
        rst_out_n = rst_out & ~pend;
        cnt_n     = '0;
        state_n   = HOLD;
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (any_pend) begin
          rst_out_n = rst_out | sel;
          pend_n    = remaining;
        end
        if (any_pend && (|remaining)) begin
          cnt_n   = '0;
          state_n = (GAP_CYCLES > 0) ? GAP : RELEASE;
        end else begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // req_rdy rises one edge after the sequence returns to IDLE and drops on
  // the accepting edge, so a held request cannot be taken twice.
  // err is delayed one stage so it lands on the edge after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      pend        <= '1;
      cnt         <= '0;
      rst_out     <= '0;
      err_pend    <= 1'b0;
      bus.busy    <= 1'b1;
      bus.req_rdy <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      state       <= state_n;
      pend        <= pend_n;
      cnt         <= cnt_n;
      rst_out     <= rst_out_n;
      err_pend    <= err_n;
      bus.busy    <= (state_n != IDLE);
      bus.req_rdy <= (state == IDLE) && (state_n == IDLE);
      bus.done    <= done_n;
      bus.err     <= err_pend;
    end
  end

endmodule

// File: tb/tb_cfg_rst_sequencer.sv
// Self-checking bench for cfg_rst_sequencer. Expected rst_out transitions and
// done pulses are queued when stimulus is driven and compared as they appear.
module tb_cfg_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] rst_out;
  logic [2:0] rst_out2;
  logic [2:0] prev;

  typedef struct {
    int         at;
    logic [2:0] val;
  } ev_t;

  ev_t ev_q[$];
  int  done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cfg_rst_sequencer_if #(.N_RST(3)) bus ();
  cfg_rst_sequencer_if #(.N_RST(3)) bus2 ();

  cfg_rst_sequencer #(
    .N_RST       (3),
    .HOLD_CYCLES (16),
    .GAP_CYCLES  (4),
    .CNT_W       (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .rst_out (rst_out)
  );

  cfg_rst_sequencer #(
    .N_RST       (3),
    .HOLD_CYCLES (16),
    .GAP_CYCLES  (0),
    .CNT_W       (8)
  ) dut_gap0 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2),
    .rst_out (rst_out2)
  );

  task automatic test_reset();
    int  r;
    ev_t ev;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_out !== 3'b000 || bus.busy !== 1'b1 || bus.req_rdy !== 1'b0 ||
          bus.done !== 1'b0 || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: rst_out=%b busy=%b req_rdy=%b done=%b err=%b, want 000 1 0 0 0",
                 rst_out, bus.busy, bus.req_rdy, bus.done, bus.err);
      end
    end
    rst = 1'b0;
    r   = cyc + 1;
    ev_q.push_back(ev_t'{r + 16, 3'b001});
    ev_q.push_back(ev_t'{r + 21, 3'b011});
    ev_q.push_back(ev_t'{r + 26, 3'b111});
    done_q.push_back(r + 26);
    prev = 3'b000;
    for (int k = 0; k < 60 && (ev_q.size() > 0 || done_q.size() > 0); k++) begin
      @(posedge clk); #1;
      if (rst_out !== prev) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL power_on_unexpected: cycle %0d rst_out=%b", cyc - r, rst_out);
        end else begin
          ev = ev_q.pop_front();
          if (cyc != ev.at || rst_out !== ev.val) begin
            errors++;
            $display("FAIL power_on_release: got %b at R+%0d, want %b at R+%0d",
                     rst_out, cyc - r, ev.val, ev.at - r);
          end
        end
        prev = rst_out;
      end
      if (bus.done === 1'b1 || (done_q.size() > 0 && cyc == done_q[0])) begin
        checks++;
        if (done_q.size() == 0 || cyc != done_q[0] || bus.done !== 1'b1) begin
          errors++;
          $display("FAIL power_on_done: done=%b at R+%0d, want 1 at R+26", bus.done, cyc - r);
        end
        if (done_q.size() > 0 && cyc == done_q[0]) void'(done_q.pop_front());
      end
    end
    if (ev_q.size() > 0 || done_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL power_on_timeout: %0d releases and %0d done pulses missing", ev_q.size(), done_q.size());
      ev_q.delete(); done_q.delete();
    end
    @(posedge clk); #1;
    checks++;
    if (bus.req_rdy !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL power_on_ready: req_rdy=%b busy=%b at R+%0d, want 1 0 at R+27",
               bus.req_rdy, bus.busy, cyc - r);
    end
  endtask

  task automatic test_mask_release();
    int  t;
    ev_t ev;
    for (int k = 0; k < 20 && bus.req_rdy !== 1'b1; k++) begin @(posedge clk); #1; end
    if (bus.req_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL mask_ready_wait: req_rdy=%b, want 1", bus.req_rdy);
    end
    prev = rst_out;
    bus.req_vld  = 1'b1;
    bus.req_mask = 3'b101;
    t = cyc + 1;
    ev_q.push_back(ev_t'{t + 1,  3'b010});
    ev_q.push_back(ev_t'{t + 18, 3'b011});
    ev_q.push_back(ev_t'{t + 23, 3'b111});
    done_q.push_back(t + 23);
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.req_rdy !== 1'b0 || rst_out !== 3'b111) begin
      errors++;
      $display("FAIL mask_accept: busy=%b req_rdy=%b rst_out=%b at T, want 1 0 111",
               bus.busy, bus.req_rdy, rst_out);
    end
    for (int k = 0; k < 60 && (ev_q.size() > 0 || done_q.size() > 0); k++) begin
      @(posedge clk); #1;
      if (rst_out !== prev) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL mask_unexpected: T+%0d rst_out=%b", cyc - t, rst_out);
        end else begin
          ev = ev_q.pop_front();
          if (cyc != ev.at || rst_out !== ev.val) begin
            errors++;
            $display("FAIL mask_release: got %b at T+%0d, want %b at T+%0d",
                     rst_out, cyc - t, ev.val, ev.at - t);
          end
        end
        prev = rst_out;
      end
      if (bus.done === 1'b1 || (done_q.size() > 0 && cyc == done_q[0])) begin
        checks++;
        if (done_q.size() == 0 || cyc != done_q[0] || bus.done !== 1'b1) begin
          errors++;
          $display("FAIL mask_done: done=%b at T+%0d, want 1 at T+23", bus.done, cyc - t);
        end
        if (done_q.size() > 0 && cyc == done_q[0]) void'(done_q.pop_front());
      end
    end
    if (ev_q.size() > 0 || done_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL mask_timeout: %0d releases and %0d done pulses missing", ev_q.size(), done_q.size());
      ev_q.delete(); done_q.delete();
    end
  endtask

  task automatic test_zero_mask();
    int t;
    for (int k = 0; k < 20 && bus.req_rdy !== 1'b1; k++) begin @(posedge clk); #1; end
    if (bus.req_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL zero_ready_wait: req_rdy=%b, want 1", bus.req_rdy);
    end
    bus.req_vld  = 1'b1;
    bus.req_mask = 3'b000;
    t = cyc + 1;
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    checks++;
    if (bus.err !== 1'b0 || bus.req_rdy !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_at_T: err=%b req_rdy=%b busy=%b at T+%0d, want 0 1 0",
               bus.err, bus.req_rdy, bus.busy, cyc - t);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b1 || rst_out !== 3'b111 || bus.req_rdy !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_err_pulse: err=%b rst_out=%b req_rdy=%b busy=%b at T+1, want 1 111 1 0",
               bus.err, rst_out, bus.req_rdy, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b0 || rst_out !== 3'b111) begin
      errors++;
      $display("FAIL zero_err_end: err=%b rst_out=%b at T+2, want 0 111", bus.err, rst_out);
    end
  endtask

  task automatic test_busy_hold();
    int  t;
    ev_t ev;
    for (int k = 0; k < 20 && bus.req_rdy !== 1'b1; k++) begin @(posedge clk); #1; end
    if (bus.req_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL hold_ready_wait: req_rdy=%b, want 1", bus.req_rdy);
    end
    prev = rst_out;
    bus.req_vld  = 1'b1;
    bus.req_mask = 3'b001;
    t = cyc + 1;
    ev_q.push_back(ev_t'{t + 1,  3'b110});
    ev_q.push_back(ev_t'{t + 18, 3'b111});
    ev_q.push_back(ev_t'{t + 21, 3'b101});
    ev_q.push_back(ev_t'{t + 38, 3'b111});
    done_q.push_back(t + 18);
    done_q.push_back(t + 38);
    @(posedge clk); #1;
    bus.req_mask = 3'b010;
    for (int k = 0; k < 80 && (ev_q.size() > 0 || done_q.size() > 0); k++) begin
      @(posedge clk); #1;
      if (cyc == t + 20) bus.req_vld = 1'b0;
      if (rst_out !== prev) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL hold_unexpected: T+%0d rst_out=%b", cyc - t, rst_out);
        end else begin
          ev = ev_q.pop_front();
          if (cyc != ev.at || rst_out !== ev.val) begin
            errors++;
            $display("FAIL hold_release: got %b at T+%0d, want %b at T+%0d",
                     rst_out, cyc - t, ev.val, ev.at - t);
          end
        end
        prev = rst_out;
      end
      if (bus.done === 1'b1 || (done_q.size() > 0 && cyc == done_q[0])) begin
        checks++;
        if (done_q.size() == 0 || cyc != done_q[0] || bus.done !== 1'b1) begin
          errors++;
          $display("FAIL hold_done: done=%b at T+%0d", bus.done, cyc - t);
        end
        if (done_q.size() > 0 && cyc == done_q[0]) void'(done_q.pop_front());
      end
      if (bus.req_rdy === 1'b1) begin
        checks++;
        if (cyc != t + 19) begin
          errors++;
          $display("FAIL hold_req_rdy: req_rdy=1 at T+%0d, want only at T+19", cyc - t);
        end
      end
    end
    bus.req_vld = 1'b0;
    if (ev_q.size() > 0 || done_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL hold_timeout: %0d releases and %0d done pulses missing", ev_q.size(), done_q.size());
      ev_q.delete(); done_q.delete();
    end
  endtask

  task automatic test_mid_reset();
    int  t;
    int  r;
    ev_t ev;
    for (int k = 0; k < 20 && bus.req_rdy !== 1'b1; k++) begin @(posedge clk); #1; end
    if (bus.req_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL midrst_ready_wait: req_rdy=%b, want 1", bus.req_rdy);
    end
    prev = rst_out;
    bus.req_vld  = 1'b1;
    bus.req_mask = 3'b101;
    t = cyc + 1;
    r = t + 11;
    ev_q.push_back(ev_t'{t + 1,  3'b010});
    ev_q.push_back(ev_t'{t + 10, 3'b000});
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    for (int k = 0; k < 80 && (ev_q.size() > 0 || done_q.size() > 0); k++) begin
      @(posedge clk); #1;
      if (rst_out !== prev) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL midrst_unexpected: T+%0d rst_out=%b", cyc - t, rst_out);
        end else begin
          ev = ev_q.pop_front();
          if (cyc != ev.at || rst_out !== ev.val) begin
            errors++;
            $display("FAIL midrst_release: got %b at T+%0d, want %b at T+%0d",
                     rst_out, cyc - t, ev.val, ev.at - t);
          end
        end
        prev = rst_out;
      end
      if (bus.done === 1'b1 || (done_q.size() > 0 && cyc == done_q[0])) begin
        checks++;
        if (done_q.size() == 0 || cyc != done_q[0] || bus.done !== 1'b1) begin
          errors++;
          $display("FAIL midrst_done: done=%b at R+%0d, want 1 at R+26", bus.done, cyc - r);
        end
        if (done_q.size() > 0 && cyc == done_q[0]) void'(done_q.pop_front());
      end
      if (cyc == t + 9) rst = 1'b1;
      if (cyc == t + 10) begin
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.req_rdy !== 1'b0) begin
          errors++;
          $display("FAIL midrst_state: busy=%b req_rdy=%b on reset edge, want 1 0", bus.busy, bus.req_rdy);
        end
        ev_q.push_back(ev_t'{r + 16, 3'b001});
        ev_q.push_back(ev_t'{r + 21, 3'b011});
        ev_q.push_back(ev_t'{r + 26, 3'b111});
        done_q.push_back(r + 26);
      end
    end
    rst = 1'b0;
    if (ev_q.size() > 0 || done_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL midrst_timeout: %0d releases and %0d done pulses missing", ev_q.size(), done_q.size());
      ev_q.delete(); done_q.delete();
    end
  endtask

  task automatic test_gap0();
    int  t;
    ev_t ev;
    for (int k = 0; k < 40 && bus2.req_rdy !== 1'b1; k++) begin @(posedge clk); #1; end
    if (bus2.req_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL gap0_ready_wait: req_rdy=%b, want 1", bus2.req_rdy);
    end
    prev = rst_out2;
    bus2.req_vld  = 1'b1;
    bus2.req_mask = 3'b111;
    t = cyc + 1;
    ev_q.push_back(ev_t'{t + 1,  3'b000});
    ev_q.push_back(ev_t'{t + 18, 3'b001});
    ev_q.push_back(ev_t'{t + 19, 3'b011});
    ev_q.push_back(ev_t'{t + 20, 3'b111});
    done_q.push_back(t + 20);
    @(posedge clk); #1;
    bus2.req_vld = 1'b0;
    for (int k = 0; k < 60 && (ev_q.size() > 0 || done_q.size() > 0); k++) begin
      @(posedge clk); #1;
      if (rst_out2 !== prev) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL gap0_unexpected: T+%0d rst_out=%b", cyc - t, rst_out2);
        end else begin
          ev = ev_q.pop_front();
          if (cyc != ev.at || rst_out2 !== ev.val) begin
            errors++;
            $display("FAIL gap0_release: got %b at T+%0d, want %b at T+%0d",
                     rst_out2, cyc - t, ev.val, ev.at - t);
          end
        end
        prev = rst_out2;
      end
      if (bus2.done === 1'b1 || (done_q.size() > 0 && cyc == done_q[0])) begin
        checks++;
        if (done_q.size() == 0 || cyc != done_q[0] || bus2.done !== 1'b1) begin
          errors++;
          $display("FAIL gap0_done: done=%b at T+%0d, want 1 at T+20", bus2.done, cyc - t);
        end
        if (done_q.size() > 0 && cyc == done_q[0]) void'(done_q.pop_front());
      end
    end
    if (ev_q.size() > 0 || done_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL gap0_timeout: %0d releases and %0d done pulses missing", ev_q.size(), done_q.size());
      ev_q.delete(); done_q.delete();
    end
  endtask

  initial begin
    bus.req_vld   = 1'b0;
    bus.req_mask  = 3'b000;
    bus2.req_vld  = 1'b0;
    bus2.req_mask = 3'b000;
    test_reset();
    test_mask_release();
    test_zero_mask();
    test_busy_hold();
    test_mid_reset();
    test_gap0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
